// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter feeding one shared serial transmitter
//
// N_REQ requesters compete for one serial transmitter. A winner is chosen in
// IDLE by round-robin, its word is latched and loaded into the transmitter,
// DATA_W serial bit cycles follow, and the winner is acked. The transmitter's
// done flag is cross-checked against the internal bit count.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req        per-requester level request, held until acked
//   i_data       packed words, requester k at [k*DATA_W +: DATA_W]
//   i_tx_done    transmitter done, expected only in the last bit cycle
//   o_ack        one-cycle pulse to the requester whose frame completed
//   o_tx_load    one-cycle load strobe to the transmitter
//   o_tx_data    latched word presented to the transmitter
//   o_bit_valid  high during the DATA_W frame bit cycles
//   o_grant_id   index of the requester being served
//   o_busy       high whenever the FSM is not idle
//   o_err        sticky done/bit-count misalignment flag
module tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  input  logic                    i_tx_done,
  output logic [N_REQ-1:0]        o_ack,
  output logic                    o_tx_load,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    o_bit_valid,
  output logic [2:0]              o_grant_id,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_ACK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       last_served;

  // Rotate the request vector so bit 0 is the requester just after
  // last_served; the lowest set bit of the rotated vector is the winner.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [3:0]         rot_amt;
  logic               found;
  logic [2:0]         winner;
  logic [DATA_W-1:0]  win_data;

  always_comb begin
    rot_amt  = {1'b0, last_served} + 4'd1;
    req_dbl  = {i_req, i_req} >> rot_amt;
    req_rot  = req_dbl[N_REQ-1:0];
    found    = 1'b0;
    winner   = 3'd0;
    win_data = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_rot[j]) begin
        found  = 1'b1;
        winner = 3'((int'(last_served) + 1 + j) % N_REQ);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (3'(k) == winner) win_data = i_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      last_served <= 3'(N_REQ - 1);
      o_ack       <= '0;
      o_tx_load   <= 1'b0;
      o_tx_data   <= '0;
      o_bit_valid <= 1'b0;
      o_grant_id  <= 3'd0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_tx_load <= 1'b0;
      o_ack     <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            o_grant_id <= winner;
            o_tx_data  <= win_data;
            o_tx_load  <= 1'b1;
            o_busy     <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          bit_cnt     <= '0;
          o_bit_valid <= 1'b1;
          state       <= S_SHIFT;
        end
        S_SHIFT: begin
          // Done must coincide exactly with the last bit cycle.
          if (i_tx_done != (bit_cnt == LAST_BIT)) o_err <= 1'b1;
          if (bit_cnt == LAST_BIT) begin
            o_bit_valid <= 1'b0;
            o_ack       <= N_REQ'(1) << o_grant_id;
            state       <= S_ACK;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_ACK: begin
          last_served <= o_grant_id;
          o_busy      <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - self-checking bench for tx_arbiter
module tb_tx_arbiter;

  localparam int N = 4;
  localparam int W = 10;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic [N-1:0]   i_req = '0;
  logic [N*W-1:0] i_data = '0;
  logic           i_tx_done = 1'b0;
  logic [N-1:0]   o_ack;
  logic           o_tx_load;
  logic [W-1:0]   o_tx_data;
  logic           o_bit_valid;
  logic [2:0]     o_grant_id;
  logic           o_busy;
  logic           o_err;

  tx_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_data(i_data),
    .i_tx_done(i_tx_done), .o_ack(o_ack), .o_tx_load(o_tx_load),
    .o_tx_data(o_tx_data), .o_bit_valid(o_bit_valid), .o_grant_id(o_grant_id),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: who was served last, and the sticky error.
  int model_last = N - 1;
  bit model_err  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int j = 1; j <= N; j++) begin
      if (req[(last + j) % N]) return (last + j) % N;
    end
    return -1;
  endfunction

  // Enter with the DUT idle, 1 time unit after a rising edge. Runs one full
  // 13-cycle frame and returns with the DUT idle again at the same phase.
  task automatic do_frame(input logic [N-1:0] req, input logic [N*W-1:0] data,
                          input int err_n, input bit chg, input bit drop,
                          output int got_id);
    int win;
    logic [W-1:0] word;
    i_req  = req;
    i_data = data;
    win    = rr_pick(req, model_last);
    word   = data[win*W +: W];
    @(posedge i_clk); #1;
    chk("load_strobe", o_tx_load, 1);
    chk("load_busy", o_busy, 1);
    chk("load_valid", o_bit_valid, 0);
    chk("grant_id", o_grant_id, win);
    chk("tx_data", o_tx_data, word);
    got_id = int'(o_grant_id);
    if (drop) i_req = '0;
    for (int n = 0; n < W; n++) begin
      @(posedge i_clk); #1;
      chk("bit_valid", o_bit_valid, 1);
      chk("bit_load", o_tx_load, 0);
      chk("bit_ack", o_ack, 0);
      chk("serial_bit", o_tx_data[n], word[n]);
      chk("err_shift", o_err, model_err);
      if (chg) i_data = {$urandom, $urandom};
      i_tx_done = (n == W - 1) || (n == err_n);
      if (n == err_n && n != W - 1) model_err = 1'b1;
    end
    @(posedge i_clk); #1;
    i_tx_done = 1'b0;
    chk("ack", o_ack, 1 << win);
    chk("ack_valid", o_bit_valid, 0);
    chk("ack_load", o_tx_load, 0);
    chk("ack_err", o_err, model_err);
    model_last = win;
    i_req = '0;
    @(posedge i_clk); #1;
    chk("idle_busy", o_busy, 0);
    chk("idle_ack", o_ack, 0);
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req = '0;
    i_tx_done = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    model_last = N - 1;
    model_err  = 1'b0;
    @(posedge i_clk); #1;
  endtask

  int got;
  int order_all[5] = '{0, 1, 2, 3, 0};
  int order_fair[4] = '{0, 2, 0, 2};
  logic [N-1:0] rreq;

  initial begin
    reset_dut();
    chk("rst_ack", o_ack, 0);
    chk("rst_load", o_tx_load, 0);
    chk("rst_data", o_tx_data, 0);
    chk("rst_valid", o_bit_valid, 0);
    chk("rst_grant", o_grant_id, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);

    // Single requester, known word
    do_frame(4'b0001, {30'h0, 10'h2B5}, -1, 0, 0, got);
    chk("single_id", got, 0);
    chk("single_err", o_err, 0);

    // All requesting: rotation from reset
    reset_dut();
    foreach (order_all[i]) begin
      do_frame(4'b1111, {$urandom, $urandom}, -1, 0, 0, got);
      chk("order_all", got, order_all[i]);
    end

    // Fairness between 0 and 2
    reset_dut();
    foreach (order_fair[i]) begin
      do_frame(4'b0101, {$urandom, $urandom}, -1, 0, 0, got);
      chk("order_fair", got, order_fair[i]);
    end

    // Misaligned done in shift cycle 4; flag stays set into the next frame
    do_frame(4'b1000, {$urandom, $urandom}, 4, 0, 0, got);
    chk("err_sticky", o_err, 1);
    do_frame(4'b0010, {$urandom, $urandom}, -1, 0, 0, got);
    chk("err_still", o_err, 1);

    // Reset during shift cycle 5
    reset_dut();
    i_req = 4'b0010;
    i_data = {$urandom, $urandom};
    @(posedge i_clk); #1;
    repeat (6) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_bit_valid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_data", o_tx_data, 0);
    chk("arst_grant", o_grant_id, 0);
    chk("arst_ack", o_ack, 0);
    chk("arst_err", o_err, 0);
    repeat (2) begin
      @(posedge i_clk); #1;
      chk("arst_hold_ack", o_ack, 0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_req = '0;
    model_last = N - 1;
    model_err  = 1'b0;
    @(posedge i_clk); #1;
    do_frame(4'b0010, {$urandom, $urandom}, -1, 0, 0, got);
    chk("regrant_id", got, 1);

    // Data changes during shift must not disturb the latched word
    do_frame(4'b0100, {$urandom, $urandom}, -1, 1, 0, got);
    chk("chg_id", got, 2);

    // Randomized frames
    for (int r = 0; r < 20; r++) begin
      rreq = 4'($urandom_range(1, 15));
      do_frame(rreq, {$urandom, $urandom}, -1, 1'($urandom), 1'($urandom), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one serial transmitter (legal 2..8).
REQ-002 Parameter DATA_W, default 10, width of each word and number of serial bit cycles per frame.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  N_REQ  per-requester level request; held high until acknowledged.
REQ-006 i_data  input  N_REQ*DATA_W  packed words; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-007 i_tx_done  input  1  done flag from the transmitter (high in the cycle its last bit is presented).
REQ-008 o_ack  output  N_REQ  one-cycle pulse to the requester whose frame just completed.
REQ-009 o_tx_load  output  1  load strobe to the transmitter's count-valid input.
REQ-010 o_tx_data  output  DATA_W  word presented to the transmitter, registered.
REQ-011 o_bit_valid  output  1  high exactly in the DATA_W cycles the transmitter's serial bit is a frame bit.
REQ-012 o_grant_id  output  3  index of the requester currently being served.
REQ-013 o_busy  output  1  high in every state except IDLE.
REQ-014 o_err  output  1  sticky flag: transmitter done did not align with the internal bit count.

Function
REQ-015 FSM states IDLE, LOAD, SHIFT, ACK; one state per cycle except SHIFT.
REQ-016 IDLE: if any i_req bit high, select winner by round-robin, latch its word into o_tx_data and index into o_grant_id, go to LOAD; else stay.
REQ-017 Round-robin: search starts at (last_served+1) mod N_REQ, first high i_req wins; after reset last_served = N_REQ-1 so requester 0 has highest priority.
REQ-018 LOAD: o_tx_load=1 for exactly one cycle; clear bit counter to 0; next state SHIFT.
REQ-019 SHIFT: o_bit_valid=1; bit counter increments each cycle; leave after DATA_W cycles (counter == DATA_W-1) to ACK.
REQ-020 Transmitter output bit n (LSB first) is valid in the n-th SHIFT cycle, n = 0..DATA_W-1; first SHIFT cycle is the cycle after LOAD.
REQ-021 Alignment check: i_tx_done must be 1 in the last SHIFT cycle and 0 in earlier SHIFT cycles; any violation sets o_err; i_tx_done ignored outside SHIFT.
REQ-022 ACK: o_ack[o_grant_id]=1 for one cycle; last_served <= o_grant_id; next state IDLE.
REQ-023 Frame period is DATA_W+3 cycles (IDLE, LOAD, DATA_W SHIFT, ACK); no back-to-back skip of IDLE.
REQ-024 i_req and i_data are sampled only in IDLE; changes during LOAD/SHIFT/ACK do not affect the current frame.
REQ-025 A requester dropping i_req before ack loses nothing already latched; its frame completes and is acked.
REQ-026 o_tx_load, o_bit_valid, o_ack never high in the same cycle; at most one o_ack bit high.
REQ-027 o_err clears only on reset.

Reset
REQ-028 Reset is asynchronous on i_rst_n low and released synchronously to i_clk.
REQ-029 During reset: state IDLE, o_ack=0, o_tx_load=0, o_tx_data=0, o_bit_valid=0, o_grant_id=0, o_busy=0, o_err=0, bit counter 0, last_served=N_REQ-1.
REQ-030 Reset mid-frame aborts immediately; no ack issued for the aborted frame; after release the first grant again follows REQ-017.

Verification
REQ-031 Single request: i_req=0001, word0=10'h2B5 -> o_tx_load one cycle later, serial bits 1,0,1,0,1,1,0,1,0,1 over 10 o_bit_valid cycles, o_ack=0001 at cycle 12 after request seen, o_err=0.
REQ-032 All request: i_req=1111 held, each acked then re-raised -> grant order 0,1,2,3,0, each frame 13 cycles, one o_ack pulse per frame.
REQ-033 Fairness: i_req=0101 continuously -> grants alternate 0,2,0,2; requesters 1 and 3 never acked.
REQ-034 Misaligned done: model forces i_tx_done high in SHIFT cycle 4 -> o_err rises next cycle and stays 1; frame still completes and acks.
REQ-035 Reset in SHIFT cycle 5 with i_req=0010 -> all outputs zero asynchronously, no o_ack; after release requester 1 regranted, full 10-bit frame sent.
REQ-036 Data change: i_data for granted requester changed during SHIFT -> transmitted bits equal the word latched in IDLE.
